// File: rtl/i2c_master_cmd_queue_pkg.sv
// Shared encodings for the I2C master command queue: master FSM states,
// sequencer states and the layout of one queued command.
package i2c_master_cmd_queue_pkg;

    typedef enum logic [2:0] {
        M_IDLE    = 3'd0,
        M_START   = 3'd1,
        M_ACK1    = 3'd2,
        M_ADDRESS = 3'd3,
        M_STOP    = 3'd5,
        M_DATA    = 3'd6,
        M_ACK2    = 3'd7
    } master_state_e;

    typedef enum logic [1:0] {
        Q_IDLE,
        Q_ISSUE,
        Q_BUSY,
        Q_RESP
    } seq_state_e;

    typedef struct packed {
        logic       rw;
        logic [6:0] addr;
        logic [7:0] wdata;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

endpackage

// File: rtl/i2c_master_cmd_queue_fifo.sv
// Small command FIFO; pointers carry one extra wrap bit so full and empty
// can be told apart when the index bits match.
module i2c_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk1,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage is deliberately left out of reset; the pointers alone define validity.
    always_ff @(posedge clk1) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/i2c_master_cmd_queue.sv
// Host command front end for the I2C master: queues single-byte requests,
// issues them one at a time and returns one response per command.
module i2c_master_cmd_queue
    import i2c_master_cmd_queue_pkg::*;
#(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk1,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rw,
    input  logic [6:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_rw,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_timeout,
    output logic [6:0] slave_address,
    output logic [7:0] data_send_master,
    output logic       data_send_master_enable,
    output logic       read,
    input  logic [2:0] state,
    input  logic       ack,
    input  logic [7:0] data_receive_master,
    input  logic       data_receive_master_enable
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    cmd_t       push_entry;
    cmd_t       head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;

    seq_state_e q_state, q_next;
    logic [TW-1:0] wd_cnt, wd_cnt_d;
    logic       wd_expired;
    logic       cur_rw, cur_rw_d;
    logic       addr_ack, addr_ack_d;
    logic       data_ack, data_ack_d;
    logic       stop_seen, stop_seen_d;
    logic [7:0] rdata, rdata_d;
    logic [6:0] slave_address_d;
    logic [7:0] data_send_master_d;
    logic       enable_d, read_d;
    logic       rsp_valid_d, rsp_rw_d, rsp_nack_d, rsp_timeout_d;
    logic [7:0] rsp_rdata_d;

    assign push_entry = {cmd_rw, cmd_addr, cmd_wdata};
    assign cmd_ready  = !fifo_full;
    assign wd_expired = (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

    i2c_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk1      (clk1),
        .rst       (rst),
        .push      (cmd_valid && !fifo_full),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            q_state                 <= Q_IDLE;
            wd_cnt                  <= '0;
            cur_rw                  <= 1'b0;
            addr_ack                <= 1'b0;
            data_ack                <= 1'b0;
            stop_seen               <= 1'b0;
            rdata                   <= '0;
            slave_address           <= '0;
            data_send_master        <= '0;
            data_send_master_enable <= 1'b0;
            read                    <= 1'b0;
            rsp_valid               <= 1'b0;
            rsp_rw                  <= 1'b0;
            rsp_rdata               <= '0;
            rsp_nack                <= 1'b0;
            rsp_timeout             <= 1'b0;
        end else begin
            q_state                 <= q_next;
            wd_cnt                  <= wd_cnt_d;
            cur_rw                  <= cur_rw_d;
            addr_ack                <= addr_ack_d;
            data_ack                <= data_ack_d;
            stop_seen               <= stop_seen_d;
            rdata                   <= rdata_d;
            slave_address           <= slave_address_d;
            data_send_master        <= data_send_master_d;
            data_send_master_enable <= enable_d;
            read                    <= read_d;
            rsp_valid               <= rsp_valid_d;
            rsp_rw                  <= rsp_rw_d;
            rsp_rdata               <= rsp_rdata_d;
            rsp_nack                <= rsp_nack_d;
            rsp_timeout             <= rsp_timeout_d;
        end
    end

    always_comb begin
        q_next             = q_state;
        fifo_pop           = 1'b0;
        wd_cnt_d           = wd_cnt;
        cur_rw_d           = cur_rw;
        addr_ack_d         = addr_ack;
        data_ack_d         = data_ack;
        stop_seen_d        = stop_seen;
        rdata_d            = rdata;
        slave_address_d    = slave_address;
        data_send_master_d = data_send_master;
        enable_d           = data_send_master_enable;
        read_d             = read;
        rsp_valid_d        = rsp_valid;
        rsp_rw_d           = rsp_rw;
        rsp_rdata_d        = rsp_rdata;
        rsp_nack_d         = rsp_nack;
        rsp_timeout_d      = rsp_timeout;

        case (q_state)
            Q_IDLE: begin
                if (!fifo_empty && state == M_IDLE) begin
                    fifo_pop           = 1'b1;
                    cur_rw_d           = head.rw;
                    slave_address_d    = head.addr;
                    data_send_master_d = head.wdata;
                    read_d             = head.rw;
                    enable_d           = !head.rw;
                    addr_ack_d         = 1'b0;
                    data_ack_d         = 1'b0;
                    stop_seen_d        = 1'b0;
                    rdata_d            = '0;
                    wd_cnt_d           = '0;
                    q_next             = Q_ISSUE;
                end
            end
            Q_ISSUE: begin
                wd_cnt_d = wd_cnt + TW'(1);
                if (state != M_IDLE) begin
                    read_d   = 1'b0;
                    enable_d = 1'b0;
                    q_next   = Q_BUSY;
                end
            end
            Q_BUSY: begin
                wd_cnt_d = wd_cnt + TW'(1);
                if (state == M_ACK1 && ack) addr_ack_d = 1'b1;
                if (!cur_rw && state == M_ACK2 && ack) data_ack_d = 1'b1;
                if (cur_rw && data_receive_master_enable) rdata_d = data_receive_master;
                if (state == M_STOP) stop_seen_d = 1'b1;
                // Completion waits for the master to come all the way back to idle after stop.
                if (stop_seen && state == M_IDLE) begin
                    rsp_valid_d   = 1'b1;
                    rsp_rw_d      = cur_rw;
                    rsp_rdata_d   = cur_rw ? rdata : 8'h00;
                    rsp_nack_d    = !addr_ack || (!cur_rw && !data_ack);
                    rsp_timeout_d = 1'b0;
                    q_next        = Q_RESP;
                end
            end
            Q_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d   = 1'b0;
                    rsp_rw_d      = 1'b0;
                    rsp_rdata_d   = '0;
                    rsp_nack_d    = 1'b0;
                    rsp_timeout_d = 1'b0;
                    q_next        = Q_IDLE;
                end
            end
            default: q_next = Q_IDLE;
        endcase

        // Watchdog abort wins over anything the master is doing this cycle.
        if ((q_state == Q_ISSUE || q_state == Q_BUSY) && wd_expired) begin
            read_d        = 1'b0;
            enable_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_rw_d      = cur_rw;
            rsp_rdata_d   = cur_rw ? rdata : 8'h00;
            rsp_nack_d    = 1'b1;
            rsp_timeout_d = 1'b1;
            q_next        = Q_RESP;
        end
    end

endmodule

// File: tb/tb_i2c_master_cmd_queue.sv
// Self-checking bench for i2c_master_cmd_queue: a behavioural I2C master model
// plus a response scoreboard filled as commands are pushed.
module tb_i2c_master_cmd_queue;
    import i2c_master_cmd_queue_pkg::*;

    logic       clk1;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_rw;
    logic [7:0] rsp_rdata;
    logic       rsp_nack;
    logic       rsp_timeout;
    logic [6:0] slave_address;
    logic [7:0] data_send_master;
    logic       data_send_master_enable;
    logic       read;
    logic [2:0] state;
    logic       ack;
    logic [7:0] data_receive_master;
    logic       data_receive_master_enable;

    int checks = 0;
    int errors = 0;

    logic [10:0] exp_q[$];
    logic        stuck = 1'b0;
    int          mstep;
    logic        mrw;
    logic [6:0]  maddr;

    i2c_master_cmd_queue #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk1                       (clk1),
        .rst                        (rst),
        .cmd_valid                  (cmd_valid),
        .cmd_ready                  (cmd_ready),
        .cmd_rw                     (cmd_rw),
        .cmd_addr                   (cmd_addr),
        .cmd_wdata                  (cmd_wdata),
        .rsp_valid                  (rsp_valid),
        .rsp_ready                  (rsp_ready),
        .rsp_rw                     (rsp_rw),
        .rsp_rdata                  (rsp_rdata),
        .rsp_nack                   (rsp_nack),
        .rsp_timeout                (rsp_timeout),
        .slave_address              (slave_address),
        .data_send_master           (data_send_master),
        .data_send_master_enable    (data_send_master_enable),
        .read                       (read),
        .state                      (state),
        .ack                        (ack),
        .data_receive_master        (data_receive_master),
        .data_receive_master_enable (data_receive_master_enable)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // Master model: steps on falling edges; address 0x7F is never acknowledged,
    // and a read returns {0,addr} ^ 0xAA.
    initial begin
        state = M_IDLE;
        ack = 1'b0;
        data_receive_master = 8'h00;
        data_receive_master_enable = 1'b0;
        mstep = 0;
        mrw = 1'b0;
        maddr = 7'h00;
        forever begin
            @(negedge clk1);
            if (!rst) begin
                state = M_IDLE;
                ack = 1'b0;
                data_receive_master_enable = 1'b0;
                mstep = 0;
            end else begin
                case (mstep)
                    0: if (state == M_IDLE && (read || data_send_master_enable)) begin
                        mrw = read;
                        maddr = slave_address;
                        state = M_START;
                        mstep = 1;
                    end
                    1: if (stuck) begin
                        if (rsp_valid) begin
                            state = M_IDLE;
                            mstep = 0;
                        end
                    end else begin
                        state = M_ADDRESS;
                        mstep = 2;
                    end
                    2: begin
                        state = M_ACK1;
                        ack = (maddr != 7'h7F);
                        mstep = 3;
                    end
                    3: begin
                        ack = 1'b0;
                        if (maddr == 7'h7F) begin
                            state = M_STOP;
                            mstep = 6;
                        end else begin
                            state = M_DATA;
                            mstep = 4;
                        end
                    end
                    4: begin
                        state = M_ACK2;
                        ack = !mrw;
                        if (mrw) begin
                            data_receive_master = {1'b0, maddr} ^ 8'hAA;
                            data_receive_master_enable = 1'b1;
                        end
                        mstep = 5;
                    end
                    5: begin
                        ack = 1'b0;
                        data_receive_master_enable = 1'b0;
                        state = M_STOP;
                        mstep = 6;
                    end
                    default: begin
                        state = M_IDLE;
                        mstep = 0;
                    end
                endcase
            end
        end
    end

    task automatic push_cmd(input logic rw, input logic [6:0] addr, input logic [7:0] wdata,
                            input logic will_timeout);
        int budget;
        logic [7:0] erd;
        budget = 0;
        while (!cmd_ready && budget < 200) begin
            @(posedge clk1); #1;
            budget++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL push_wait cmd_ready got %0b want 1", cmd_ready);
            return;
        end
        cmd_valid = 1'b1;
        cmd_rw = rw;
        cmd_addr = addr;
        cmd_wdata = wdata;
        @(posedge clk1); #1;
        cmd_valid = 1'b0;
        erd = (rw && !will_timeout) ? ({1'b0, addr} ^ 8'hAA) : 8'h00;
        exp_q.push_back({rw, erd, will_timeout || (addr == 7'h7F), will_timeout});
    endtask

    task automatic test_reset();
        logic [29:0] got;
        rst = 1'b0;
        cmd_valid = 1'b0;
        cmd_rw = 1'b0;
        cmd_addr = 7'h00;
        cmd_wdata = 8'h00;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
        got = {cmd_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_nack, rsp_timeout,
               slave_address, data_send_master, data_send_master_enable, read};
        checks++;
        if (got !== {1'b1, 29'd0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h want %h", got, {1'b1, 29'd0});
        end
        rst = 1'b1;
        repeat (2) @(posedge clk1);
        #1;
        got = {cmd_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_nack, rsp_timeout,
               slave_address, data_send_master, data_send_master_enable, read};
        checks++;
        if (got !== {1'b1, 29'd0}) begin
            errors++;
            $display("[TB] FAIL post_reset_idle got %h want %h", got, {1'b1, 29'd0});
        end
    endtask

    task automatic test_single_write();
        int n;
        logic [10:0] exp;
        push_cmd(1'b0, 7'h50, 8'hA5, 1'b0);
        checks++;
        if ({data_send_master_enable, read} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL wr_latency_early got %b want 00", {data_send_master_enable, read});
        end
        @(posedge clk1); #1;
        checks++;
        if ({data_send_master_enable, read, slave_address, data_send_master} !== {2'b10, 7'h50, 8'hA5}) begin
            errors++;
            $display("[TB] FAIL wr_request got %b/%b/%h/%h want 1/0/50/a5",
                     data_send_master_enable, read, slave_address, data_send_master);
        end
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk1); #1; n++; end
        exp = exp_q.pop_front();
        checks++;
        if (!rsp_valid || {rsp_rw, rsp_rdata, rsp_nack, rsp_timeout} !== exp) begin
            errors++;
            $display("[TB] FAIL wr_rsp got v=%0b %h want v=1 %h", rsp_valid,
                     {rsp_rw, rsp_rdata, rsp_nack, rsp_timeout}, exp);
        end
        rsp_ready = 1'b1;
        @(posedge clk1); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_single_read();
        int n;
        logic [10:0] exp;
        push_cmd(1'b1, 7'h3C, 8'h00, 1'b0);
        @(posedge clk1); #1;
        checks++;
        if ({data_send_master_enable, read, slave_address} !== {2'b01, 7'h3C}) begin
            errors++;
            $display("[TB] FAIL rd_request got %b/%b/%h want 0/1/3c",
                     data_send_master_enable, read, slave_address);
        end
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk1); #1; n++; end
        exp = exp_q.pop_front();
        checks++;
        if (!rsp_valid || {rsp_rw, rsp_rdata, rsp_nack, rsp_timeout} !== exp) begin
            errors++;
            $display("[TB] FAIL rd_rsp got v=%0b %h want v=1 %h", rsp_valid,
                     {rsp_rw, rsp_rdata, rsp_nack, rsp_timeout}, exp);
        end
        rsp_ready = 1'b1;
        @(posedge clk1); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_addr_nack();
        int n;
        logic [10:0] exp;
        push_cmd(1'b0, 7'h7F, 8'h11, 1'b0);
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk1); #1; n++; end
        exp = exp_q.pop_front();
        checks++;
        if (!rsp_valid || {rsp_rw, rsp_rdata, rsp_nack, rsp_timeout} !== exp) begin
            errors++;
            $display("[TB] FAIL nack_rsp got v=%0b %h want v=1 %h", rsp_valid,
                     {rsp_rw, rsp_rdata, rsp_nack, rsp_timeout}, exp);
        end
        rsp_ready = 1'b1;
        @(posedge clk1); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n;
        logic [10:0] exp;
        rsp_ready = 1'b0;
        push_cmd(1'b0, 7'h10, 8'h01, 1'b0);
        push_cmd(1'b1, 7'h22, 8'h00, 1'b0);
        push_cmd(1'b0, 7'h7F, 8'h02, 1'b0);
        push_cmd(1'b1, 7'h33, 8'h00, 1'b0);
        n = 0;
        while (!rsp_valid && n < 100) begin @(posedge clk1); #1; n++; end
        checks++;
        if ({rsp_valid, cmd_ready} !== 2'b11) begin
            errors++;
            $display("[TB] FAIL b2b_pending_ready got %b want 11", {rsp_valid, cmd_ready});
        end
        push_cmd(1'b0, 7'h44, 8'h5A, 1'b0);
        checks++;
        if (cmd_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_full cmd_ready got %0b want 0", cmd_ready);
        end
        for (int i = 0; i < 5; i++) begin
            n = 0;
            while (!rsp_valid && n < 100) begin @(posedge clk1); #1; n++; end
            exp = exp_q.pop_front();
            checks++;
            if (!rsp_valid || {rsp_rw, rsp_rdata, rsp_nack, rsp_timeout} !== exp) begin
                errors++;
                $display("[TB] FAIL b2b_rsp%0d got v=%0b %h want v=1 %h", i, rsp_valid,
                         {rsp_rw, rsp_rdata, rsp_nack, rsp_timeout}, exp);
            end
            rsp_ready = 1'b1;
            @(posedge clk1); #1;
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_timeout();
        logic [10:0] exp;
        stuck = 1'b1;
        push_cmd(1'b0, 7'h2A, 8'h77, 1'b1);
        @(posedge clk1); #1;
        checks++;
        if (data_send_master_enable !== 1'b1) begin
            errors++;
            $display("[TB] FAIL to_issue enable got %0b want 1", data_send_master_enable);
        end
        repeat (15) @(posedge clk1);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL to_early rsp_valid got %0b want 0", rsp_valid);
        end
        @(posedge clk1); #1;
        checks++;
        if ({rsp_valid, rsp_timeout, rsp_nack, data_send_master_enable, read} !== 5'b11100) begin
            errors++;
            $display("[TB] FAIL to_abort got %b want 11100",
                     {rsp_valid, rsp_timeout, rsp_nack, data_send_master_enable, read});
        end
        exp = exp_q.pop_front();
        checks++;
        if ({rsp_rw, rsp_rdata, rsp_nack, rsp_timeout} !== exp) begin
            errors++;
            $display("[TB] FAIL to_rsp got %h want %h", {rsp_rw, rsp_rdata, rsp_nack, rsp_timeout}, exp);
        end
        rsp_ready = 1'b1;
        @(posedge clk1); #1;
        rsp_ready = 1'b0;
        stuck = 1'b0;
        repeat (3) @(posedge clk1);
        #1;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [29:0] got;
        push_cmd(1'b0, 7'h55, 8'hC3, 1'b0);
        n = 0;
        while (state != M_DATA && n < 50) begin @(posedge clk1); #1; n++; end
        rst = 1'b0;
        #1;
        void'(exp_q.pop_back());
        got = {cmd_ready, rsp_valid, rsp_rw, rsp_rdata, rsp_nack, rsp_timeout,
               slave_address, data_send_master, data_send_master_enable, read};
        checks++;
        if (state !== M_DATA || got !== {1'b1, 29'd0}) begin
            errors++;
            $display("[TB] FAIL mid_reset state=%0d got %h want %h", state, got, {1'b1, 29'd0});
        end
        repeat (2) @(posedge clk1);
        #1;
        rst = 1'b1;
        repeat (10) @(posedge clk1);
        #1;
        checks++;
        if ({rsp_valid, data_send_master_enable, read, cmd_ready} !== 4'b0001) begin
            errors++;
            $display("[TB] FAIL mid_reset_quiet got %b want 0001",
                     {rsp_valid, data_send_master_enable, read, cmd_ready});
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_single_read();
        test_addr_nack();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_time_limit reached at %0t", $time);
        $fatal(1, "[TB] simulation time limit");
    end

endmodule
